// File: rtl/bcd_ser_pkg.sv
// rtl/bcd_ser_pkg.sv - shared types and constants for the BCD serializer
package bcd_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPW  = 2'd2
    } ser_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    // A code is a legal BCD digit when it does not exceed nine.
    function automatic logic is_bcd(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_fifo.sv
// rtl/bcd_fifo.sv - show-ahead digit FIFO, 4 bits wide
module bcd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Writes are refused when full and reads when empty, so the pointers never overrun.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // Pointer and occupancy bookkeeping; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/bcd_serializer.sv
// rtl/bcd_serializer.sv - buffers BCD digits and shifts them out MSB-first on linea
module bcd_serializer
    import bcd_ser_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int GAP          = 0,
    parameter bit DROP_INVALID = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       linea,
    output logic       linea_valid,
    output logic       digit_start,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [2:0] GAP_CYC = 3'(GAP);

    ser_state_t state;
    ser_state_t next_state;

    logic [3:0] head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       load;
    logic       head_ok;
    logic       head_loadable;
    logic       head_dropped;

    logic [3:0] shreg;
    logic [1:0] bitcnt;
    logic [2:0] gapcnt;

    // Accept only when there is room; a pop in the same cycle does not open a slot early.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    bcd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // A head code is shifted unless it is out of range and dropping is enabled.
    assign head_ok       = is_bcd(head);
    assign head_loadable = !empty && (head_ok || !DROP_INVALID);
    assign head_dropped  = !empty && !head_ok && DROP_INVALID;

    // State register; reset abandons any digit in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and FIFO pop decision.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (head_loadable) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    next_state = SHIFT;
                end else if (head_dropped) begin
                    pop = 1'b1;
                end
            end
            SHIFT: begin
                if (bitcnt == 2'd0) begin
                    if (GAP != 0) begin
                        next_state = GAPW;
                    end else if (head_loadable) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAPW: begin
                if (gapcnt <= 3'd1) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift register and bit counter: load on pop, otherwise shift left while shifting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (load) begin
            shreg  <= head;
            bitcnt <= 2'd3;
        end else if (state == SHIFT) begin
            shreg  <= {shreg[2:0], 1'b0};
            bitcnt <= bitcnt - 2'd1;
        end
    end

    // Gap counter: armed on the last bit of a digit, counts down while waiting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gapcnt <= '0;
        end else if (state == SHIFT && bitcnt == 2'd0 && GAP != 0) begin
            gapcnt <= GAP_CYC;
        end else if (state == GAPW) begin
            gapcnt <= gapcnt - 3'd1;
        end
    end

    // Out-of-range code counter, counted on every pop of such a code and saturating.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (pop && !head_ok && err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Serial line outputs, driven only while a payload bit is present.
    always_comb begin
        linea       = 1'b0;
        linea_valid = 1'b0;
        digit_start = 1'b0;
        if (state == SHIFT) begin
            linea       = shreg[3];
            linea_valid = 1'b1;
            digit_start = (bitcnt == 2'd3);
        end
    end

    assign busy = !empty || (state != IDLE);

endmodule

// File: tb/tb_bcd_serializer.sv
// tb/tb_bcd_serializer.sv - self-checking bench for bcd_serializer
module tb_bcd_serializer;

    localparam int NI = 3;
    localparam int DEP = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          in_valid;
    logic [3:0]    in_data;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] linea;
    logic [NI-1:0] linea_valid;
    logic [NI-1:0] digit_start;
    logic [NI-1:0] busy;
    logic [7:0]    err_cnt [NI];

    bcd_serializer #(.DEPTH(DEP), .GAP(0), .DROP_INVALID(1'b1)) u_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .linea(linea[0]), .linea_valid(linea_valid[0]),
        .digit_start(digit_start[0]), .busy(busy[0]), .err_cnt(err_cnt[0]));

    bcd_serializer #(.DEPTH(DEP), .GAP(2), .DROP_INVALID(1'b1)) u_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .linea(linea[1]), .linea_valid(linea_valid[1]),
        .digit_start(digit_start[1]), .busy(busy[1]), .err_cnt(err_cnt[1]));

    bcd_serializer #(.DEPTH(DEP), .GAP(0), .DROP_INVALID(1'b0)) u_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .linea(linea[2]), .linea_valid(linea_valid[2]),
        .digit_start(digit_start[2]), .busy(busy[2]), .err_cnt(err_cnt[2]));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a digit queue plus a schedule of what the line shows each future cycle.
    typedef struct packed {
        logic v;
        logic b;
        logic st;
        logic last;
    } slot_t;

    logic [3:0] mq [NI][$];
    slot_t      ms [NI][$];
    int         merr [NI];

    typedef struct packed {
        logic       r;
        logic       iv;
        logic [3:0] d;
        logic       lv;
        logic       l;
        logic       ds;
        logic       bz;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[$];

    int          col_sel = 0;
    logic [63:0] colbits;
    int          coln;
    logic [31:0] lvhist;
    logic [31:0] lhist;

    function automatic int gap_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic bit drop_of(input int i);
        return (i != 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input int i, input logic r, input logic iv, input logic [3:0] d);
        bit         can_push;
        bit         idle;
        bit         chain;
        logic [3:0] h;
        if (!r) begin
            mq[i].delete();
            ms[i].delete();
            merr[i] = 0;
            return;
        end
        can_push = (mq[i].size() < DEP);
        idle     = (ms[i].size() == 0);
        chain    = (ms[i].size() == 1) && ms[i][0].last && (gap_of(i) == 0);
        if (ms[i].size() != 0) void'(ms[i].pop_front());
        if ((idle || chain) && mq[i].size() != 0) begin
            h = mq[i][0];
            if (!(chain && h > 9 && drop_of(i))) begin
                void'(mq[i].pop_front());
                if (h > 9 && merr[i] < 255) merr[i]++;
                if (!(h > 9 && drop_of(i))) begin
                    for (int k = 3; k >= 0; k--)
                        ms[i].push_back('{1'b1, h[k], (k == 3), (k == 0)});
                    for (int g = 0; g < gap_of(i); g++)
                        ms[i].push_back('{1'b0, 1'b0, 1'b0, 1'b0});
                end
            end
        end
        if (iv && can_push) mq[i].push_back(d);
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input logic r, input logic iv, input logic [3:0] d);
        slot_t       s;
        logic [12:0] e;
        logic [12:0] o;
        reset    = r;
        in_valid = iv;
        in_data  = d;
        @(posedge clock);
        for (int i = 0; i < NI; i++) model_edge(i, r, iv, d);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            s = (ms[i].size() != 0) ? ms[i][0] : '0;
            e = {(mq[i].size() < DEP), s.v, s.b, s.st,
                 (mq[i].size() != 0 || ms[i].size() != 0), 8'(merr[i])};
            o = {in_ready[i], linea_valid[i], linea[i], digit_start[i], busy[i], err_cnt[i]};
            chk($sformatf("model%0d", i), 32'(o), 32'(e));
        end
        if (linea_valid[col_sel]) begin
            colbits = {colbits[62:0], linea[col_sel]};
            coln++;
        end
        lvhist = {lvhist[30:0], linea_valid[1]};
        lhist  = {lhist[30:0], linea[1]};
    endtask

    task automatic addv(input logic r, input logic iv, input logic [3:0] d, input logic lv,
                        input logic l, input logic ds, input logic bz, input logic [7:0] err);
        tbl.push_back('{r, iv, d, lv, l, ds, bz, err});
    endtask

    task automatic idle_rows(input int n, input logic [3:0] bits, input logic [7:0] err, input bit first);
        for (int k = 3; k >= 4 - n; k--) addv(1, 0, 0, 1, bits[k], first && k == 3, 1, err);
    endtask

    initial begin
        int   idx;
        bit   acc;
        bit   saw_low;
        int   lvcount;

        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 4'd0;
        colbits = '0;
        coln = 0;
        lvhist = '0;
        lhist = '0;

        // Single digit 5, then 3,7,9 back-to-back, then 8,12,2 with the 12 dropped.
        addv(0, 0, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 5, 0, 0, 0, 1, 0);
        idle_rows(4, 4'd5, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 0, 0);

        addv(0, 0, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 3, 0, 0, 0, 1, 0);
        addv(1, 1, 7, 1, 0, 1, 1, 0);
        addv(1, 1, 9, 1, 0, 0, 1, 0);
        addv(1, 0, 0, 1, 1, 0, 1, 0);
        addv(1, 0, 0, 1, 1, 0, 1, 0);
        idle_rows(4, 4'd7, 0, 1);
        idle_rows(4, 4'd9, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 0, 0);

        addv(0, 0, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 8, 0, 0, 0, 1, 0);
        addv(1, 1, 12, 1, 1, 1, 1, 0);
        addv(1, 1, 2, 1, 0, 0, 1, 0);
        addv(1, 0, 0, 1, 0, 0, 1, 0);
        addv(1, 0, 0, 1, 0, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 1, 1);
        idle_rows(4, 4'd2, 1, 1);
        addv(1, 0, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].r, tbl[k].iv, tbl[k].d);
            chk($sformatf("vec%0d", k),
                32'({linea_valid[0], linea[0], digit_start[0], busy[0], err_cnt[0]}),
                32'({tbl[k].lv, tbl[k].l, tbl[k].ds, tbl[k].bz, tbl[k].err}));
        end

        // Same 8,12,2 stimulus without dropping: 12 is shifted as 1100.
        col_sel = 2;
        step(0, 0, 0);
        coln = 0;
        colbits = '0;
        step(1, 1, 8);
        step(1, 1, 12);
        step(1, 1, 2);
        for (int t = 0; t < 20; t++) step(1, 0, 0);
        chk("nodrop_bits", 32'(colbits[11:0]), 32'(12'b1000_1100_0010));
        chk("nodrop_count", 32'(coln), 32'd12);
        chk("nodrop_err", 32'(err_cnt[2]), 32'd1);

        // GAP=2 instance: 0001, two gap cycles, IDLE load cycle, then 0010.
        step(0, 0, 0);
        step(1, 1, 1);
        step(1, 1, 2);
        for (int t = 0; t < 11; t++) step(1, 0, 0);
        chk("gap_valid", 32'(lvhist[12:0]), 32'(13'b0111100011110));
        chk("gap_line", 32'(lhist[12:0]), 32'(13'b0000100000100));

        // Backpressure: hold digits 1..6 on the input until each is taken.
        col_sel = 0;
        step(0, 0, 0);
        coln = 0;
        colbits = '0;
        idx = 1;
        saw_low = 0;
        for (int t = 0; t < 100 && idx <= 6; t++) begin
            acc = in_ready[0];
            if (!acc) saw_low = 1;
            step(1, 1, 4'(idx));
            if (acc) idx++;
        end
        for (int t = 0; t < 40; t++) step(1, 0, 0);
        chk("bp_all_taken", 32'(idx), 32'd7);
        chk("bp_ready_low", 32'(saw_low), 32'd1);
        chk("bp_count", 32'(coln), 32'd24);
        chk("bp_order", 32'(colbits[23:0]), 32'h123456);

        // Reset during bit 2 of digit 6 with 7 and 8 queued.
        step(0, 0, 0);
        step(1, 1, 6);
        step(1, 1, 7);
        step(1, 1, 8);
        chk("mid_bit2", 32'({linea_valid[0], digit_start[0], linea[0]}), 32'b101);
        step(0, 0, 0);
        chk("mid_reset", 32'({linea_valid[0], busy[0], err_cnt[0]}), 32'd0);
        lvcount = 0;
        for (int t = 0; t < 12; t++) begin
            step(1, 0, 0);
            if (linea_valid[0]) lvcount++;
        end
        chk("mid_no_emit", 32'(lvcount), 32'd0);

        // Error counter saturation with a long run of code 15.
        step(0, 0, 0);
        for (int t = 0; t < 300; t++) step(1, 1, 4'd15);
        for (int t = 0; t < 30; t++) step(1, 0, 0);
        chk("err_sat", 32'(err_cnt[0]), 32'd255);

        // Random traffic against the model, with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) != 0) && (t % 400 < 300),
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
